// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU even-pipe issue path.
// Latency encodings, register-file sizing and the issue bundle.
package spu_pkg;

    localparam int NUM_REGS = 128;
    localparam int MAX_LAT  = 7;
    localparam int LAT_FP   = 6;
    localparam int LAT_INT  = 7;

    localparam int REG_W = 7;
    localparam int LAT_W = 3;
    localparam int OP_W  = 11;
    localparam int FMT_W = 3;
    localparam int IMM_W = 18;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [FMT_W-1:0] format;
        logic [IMM_W-1:0] imm;
        logic [REG_W-1:0] rt_addr;
        logic             reg_write;
    } issue_t;

    function automatic logic lat_legal(input logic [LAT_W-1:0] lat);
        return lat != '0;
    endfunction

endpackage

// File: rtl/spu_reg_scoreboard.sv
// Per-register countdown scoreboard: a register is readable at zero.
// Three source read ports, one destination read port, one load port.
module spu_reg_scoreboard
    import spu_pkg::*;
#(
    parameter int NREGS = 128,
    parameter int CW    = 3,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] rc_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [CW-1:0] ra_cnt,
    output logic [CW-1:0] rb_cnt,
    output logic [CW-1:0] rc_cnt,
    output logic [CW-1:0] rt_cnt,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [CW-1:0] load_val
);

    logic [CW-1:0] cnt_q [NREGS];
    logic [CW-1:0] cnt_d [NREGS];

    // A fresh load wins over the decrement of the same entry.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (load_en && (load_addr == AW'(r))) begin
                cnt_d[r] = load_val;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign ra_cnt = cnt_q[ra_addr];
    assign rb_cnt = cnt_q[rb_addr];
    assign rc_cnt = cnt_q[rc_addr];
    assign rt_cnt = cnt_q[rt_addr];

endmodule

// File: rtl/spu_even_issue_ctrl.sv
// SPU even-pipe issue control: scoreboard, writeback-port reservation,
// hazard check, one-cycle issue register and stall statistics.
module spu_even_issue_ctrl
    import spu_pkg::*;
#(
    parameter int NUM_REGS = spu_pkg::NUM_REGS,
    parameter int MAX_LAT  = spu_pkg::MAX_LAT,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int LW       = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [FMT_W-1:0] in_format,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [AW-1:0]    in_ra_addr,
    input  logic [AW-1:0]    in_rb_addr,
    input  logic [AW-1:0]    in_rc_addr,
    input  logic             in_use_ra,
    input  logic             in_use_rb,
    input  logic             in_use_rc,
    input  logic [AW-1:0]    in_rt_addr,
    input  logic             in_reg_write,
    input  logic [LW-1:0]    in_lat,
    input  logic             flush,
    output logic             iss_valid,
    output logic [OP_W-1:0]  iss_op,
    output logic [FMT_W-1:0] iss_format,
    output logic [IMM_W-1:0] iss_imm,
    output logic [AW-1:0]    iss_rt_addr,
    output logic             iss_reg_write,
    output logic [31:0]      stall_cycles
);

    logic [LW-1:0] ra_cnt;
    logic [LW-1:0] rb_cnt;
    logic [LW-1:0] rc_cnt;
    logic [LW-1:0] rt_cnt;

    logic [MAX_LAT:1] wb_busy_q;
    logic [MAX_LAT:1] wb_busy_d;

    logic   iss_valid_q;
    logic   iss_valid_d;
    issue_t iss_q;
    issue_t iss_d;

    logic [31:0] stall_q;
    logic [31:0] stall_d;

    logic raw;
    logic waw;
    logic port_busy;
    logic accept;
    logic load_en;

    spu_reg_scoreboard #(
        .NREGS (NUM_REGS),
        .CW    (LW),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .ra_addr   (in_ra_addr),
        .rb_addr   (in_rb_addr),
        .rc_addr   (in_rc_addr),
        .rt_addr   (in_rt_addr),
        .ra_cnt    (ra_cnt),
        .rb_cnt    (rb_cnt),
        .rc_cnt    (rc_cnt),
        .rt_cnt    (rt_cnt),
        .load_en   (load_en),
        .load_addr (in_rt_addr),
        .load_val  (in_lat - LW'(1))
    );

    assign raw = (in_use_ra && (ra_cnt != '0))
              || (in_use_rb && (rb_cnt != '0))
              || (in_use_rc && (rc_cnt != '0));

    // An older write still counting >= L would land no earlier than ours.
    assign waw       = in_reg_write && (rt_cnt >= in_lat);
    assign port_busy = in_reg_write && wb_busy_q[in_lat];

    assign in_ready = !reset && !flush && !raw && !waw && !port_busy;
    assign accept   = in_valid && in_ready;
    assign load_en  = accept && in_reg_write;

    // Shifted vector: bit L-1 here is due L cycles after this accept.
    always_comb begin
        wb_busy_d = wb_busy_q >> 1;
        if (load_en && (in_lat > LW'(1))) begin
            wb_busy_d[in_lat - LW'(1)] = 1'b1;
        end
    end

    always_comb begin
        iss_valid_d = accept;
        iss_d       = '0;
        if (accept) begin
            iss_d.op        = in_op;
            iss_d.format    = in_format;
            iss_d.imm       = in_imm;
            iss_d.rt_addr   = in_rt_addr;
            iss_d.reg_write = in_reg_write;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_busy_q   <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            stall_q     <= '0;
        end else begin
            wb_busy_q   <= wb_busy_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            stall_q     <= stall_d;
        end
    end

    assign iss_valid     = iss_valid_q;
    assign iss_op        = iss_q.op;
    assign iss_format    = iss_q.format;
    assign iss_imm       = iss_q.imm;
    assign iss_rt_addr   = iss_q.rt_addr;
    assign iss_reg_write = iss_q.reg_write;
    assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_spu_even_issue_ctrl.sv
// Bench for spu_even_issue_ctrl: directed vector table, stream run,
// then random traffic against an absolute-time reference model.
module tb_spu_even_issue_ctrl;
    import spu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_op;
    logic [2:0]  in_format;
    logic [17:0] in_imm;
    logic [6:0]  in_ra_addr;
    logic [6:0]  in_rb_addr;
    logic [6:0]  in_rc_addr;
    logic        in_use_ra;
    logic        in_use_rb;
    logic        in_use_rc;
    logic [6:0]  in_rt_addr;
    logic        in_reg_write;
    logic [2:0]  in_lat;
    logic        flush;
    logic        iss_valid;
    logic [10:0] iss_op;
    logic [2:0]  iss_format;
    logic [17:0] iss_imm;
    logic [6:0]  iss_rt_addr;
    logic        iss_reg_write;
    logic [31:0] stall_cycles;

    spu_even_issue_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_format     (in_format),
        .in_imm        (in_imm),
        .in_ra_addr    (in_ra_addr),
        .in_rb_addr    (in_rb_addr),
        .in_rc_addr    (in_rc_addr),
        .in_use_ra     (in_use_ra),
        .in_use_rb     (in_use_rb),
        .in_use_rc     (in_use_rc),
        .in_rt_addr    (in_rt_addr),
        .in_reg_write  (in_reg_write),
        .in_lat        (in_lat),
        .flush         (flush),
        .iss_valid     (iss_valid),
        .iss_op        (iss_op),
        .iss_format    (iss_format),
        .iss_imm       (iss_imm),
        .iss_rt_addr   (iss_rt_addr),
        .iss_reg_write (iss_reg_write),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && in_valid) begin
            assert (lat_legal(in_lat))
            else $error("illegal latency presented: %0d", in_lat);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       v;
        logic [6:0] ra;
        logic       ua;
        logic [6:0] rt;
        logic       rw;
        logic [2:0] lat;
        logic       fl;
        logic       rst;
        logic       exp_ready;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [6:0] ra, input logic ua,
                       input logic [6:0] rt, input logic rw,
                       input logic [2:0] lat, input logic fl,
                       input logic rst, input logic er);
        vec_t r;
        r.v = v; r.ra = ra; r.ua = ua; r.rt = rt; r.rw = rw;
        r.lat = lat; r.fl = fl; r.rst = rst; r.exp_ready = er;
        tbl.push_back(r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 1, 0, 0, 1);
    endtask

    task automatic quiet();
        in_valid = 0; in_use_ra = 0; in_use_rb = 0; in_use_rc = 0;
        in_ra_addr = 0; in_rb_addr = 0; in_rc_addr = 0;
        in_rt_addr = 0; in_reg_write = 0; in_lat = 3'd1; flush = 0;
        in_op = 0; in_format = 0; in_imm = 0;
    endtask

    // Reference model in absolute cycle time.
    int     cyc;
    int     ready_at [128];
    bit     wb_res [int];
    logic   e_iss_v;
    issue_t e_iss;
    logic [31:0] e_stall;

    function automatic logic model_ready();
        if (reset || flush) return 1'b0;
        if (in_use_ra && ready_at[in_ra_addr] > cyc) return 1'b0;
        if (in_use_rb && ready_at[in_rb_addr] > cyc) return 1'b0;
        if (in_use_rc && ready_at[in_rc_addr] > cyc) return 1'b0;
        if (in_reg_write) begin
            if (ready_at[in_rt_addr] - cyc >= int'(in_lat)) return 1'b0;
            if (wb_res.exists(cyc + int'(in_lat))) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 128; r++) ready_at[r] = 0;
        wb_res.delete();
        e_iss_v = 0;
        e_iss   = '0;
        e_stall = 0;
    endtask

    initial begin
        logic       prev_acc;
        logic [6:0] prev_rt;
        logic [10:0] prev_op;
        logic [31:0] exp_stall;
        int          pulses;
        logic        er;
        logic        acc;

        quiet();
        reset = 1;
        @(posedge clk); #1;

        add(1, 0, 0, 1, 1, 6, 0, 1, 0);
        add(1, 0, 0, 1, 1, 6, 0, 1, 0);
        add(1, 0, 0, 1, 1, 6, 0, 1, 0);
        idle(1);
        add(1, 0, 0, 5, 1, 6, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(1, 5, 1, 0, 0, 6, 0, 0, 0);
        add(1, 5, 1, 0, 0, 6, 0, 0, 1);
        idle(8);
        add(1, 0, 0, 9, 1, 7, 0, 0, 1);
        add(1, 0, 0, 9, 1, 6, 0, 0, 0);
        add(1, 0, 0, 9, 1, 6, 0, 0, 1);
        idle(8);
        add(1, 0, 0, 10, 1, 7, 0, 0, 1);
        add(1, 0, 0, 10, 1, 5, 0, 0, 0);
        add(1, 0, 0, 10, 1, 5, 0, 0, 0);
        add(1, 0, 0, 10, 1, 5, 0, 0, 1);
        idle(8);
        add(1, 0, 0, 20, 1, 7, 0, 0, 1);
        add(1, 0, 0, 21, 1, 6, 0, 0, 0);
        add(1, 0, 0, 21, 1, 6, 0, 0, 1);
        idle(8);
        add(1, 0, 0, 30, 1, 3, 0, 0, 1);
        add(1, 0, 0, 31, 1, 2, 1, 0, 0);
        add(1, 0, 0, 31, 1, 2, 0, 0, 1);
        add(1, 30, 1, 0, 0, 1, 0, 0, 1);
        idle(8);
        add(1, 0, 0, 0, 1, 2, 0, 0, 1);
        add(1, 0, 1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 40, 1, 1, 0, 0, 1);
        add(1, 40, 1, 0, 0, 1, 0, 0, 1);
        idle(8);
        add(1, 0, 0, 45, 1, 7, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0);
        add(1, 45, 1, 0, 0, 1, 0, 0, 1);
        idle(8);

        prev_acc = 0; prev_rt = 0; prev_op = 0; exp_stall = 0;
        foreach (tbl[i]) begin
            quiet();
            reset        = tbl[i].rst;
            in_valid     = tbl[i].v;
            in_ra_addr   = tbl[i].ra;
            in_use_ra    = tbl[i].ua;
            in_rt_addr   = tbl[i].rt;
            in_reg_write = tbl[i].rw;
            in_lat       = tbl[i].lat;
            flush        = tbl[i].fl;
            in_op        = 11'(i);
            #1;
            chk($sformatf("tbl%0d in_ready", i), 64'(in_ready),
                64'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d iss_valid", i), 64'(iss_valid),
                64'(prev_acc));
            chk($sformatf("tbl%0d iss_rt", i), 64'(iss_rt_addr),
                64'(prev_acc ? prev_rt : 7'd0));
            chk($sformatf("tbl%0d iss_op", i), 64'(iss_op),
                64'(prev_acc ? prev_op : 11'd0));
            chk($sformatf("tbl%0d stall", i), 64'(stall_cycles),
                64'(exp_stall));
            if (tbl[i].rst) exp_stall = 0;
            else if (tbl[i].v && !tbl[i].exp_ready) exp_stall++;
            prev_acc = tbl[i].v && tbl[i].exp_ready && !tbl[i].rst;
            prev_rt  = tbl[i].rt;
            prev_op  = 11'(i);
            @(posedge clk); #1;
        end

        pulses = 0;
        for (int i = 0; i < 22; i++) begin
            quiet();
            reset        = 0;
            in_valid     = (i < 20);
            in_rt_addr   = 7'(60 + i);
            in_reg_write = 1;
            in_lat       = 3'(LAT_FP);
            #1;
            if (i < 20) chk("stream in_ready", 64'(in_ready), 64'd1);
            chk("stream iss_valid", 64'(iss_valid),
                64'((i >= 1) && (i <= 20)));
            if (iss_valid) begin
                pulses++;
                chk("stream iss_rt", 64'(iss_rt_addr), 64'(59 + i));
            end
            @(posedge clk); #1;
        end
        chk("stream pulses", 64'(pulses), 64'd20);

        quiet();
        reset = 1;
        @(posedge clk); #1;
        cyc = 0;
        model_clear();
        for (int n = 0; n < 1500; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            in_ra_addr   = 7'($urandom_range(0, 7));
            in_rb_addr   = 7'($urandom_range(0, 7));
            in_rc_addr   = 7'($urandom_range(0, 7));
            in_use_ra    = 1'($urandom_range(0, 1));
            in_use_rb    = 1'($urandom_range(0, 1));
            in_use_rc    = ($urandom_range(0, 3) == 0);
            in_rt_addr   = 7'($urandom_range(0, 7));
            in_reg_write = ($urandom_range(0, 3) != 0);
            in_lat       = 3'($urandom_range(1, 7));
            flush        = ($urandom_range(0, 19) == 0);
            in_op        = 11'($urandom);
            in_format    = 3'($urandom);
            in_imm       = 18'($urandom);
            #1;
            er = model_ready();
            chk("rnd in_ready", 64'(in_ready), 64'(er));
            chk("rnd iss_valid", 64'(iss_valid), 64'(e_iss_v));
            chk("rnd iss_bundle",
                64'({iss_op, iss_format, iss_imm, iss_rt_addr,
                     iss_reg_write}), 64'(e_iss));
            chk("rnd stall", 64'(stall_cycles), 64'(e_stall));
            acc = in_valid && er;
            if (reset) begin
                model_clear();
            end else begin
                if (in_valid && !er && e_stall != 32'hFFFF_FFFF)
                    e_stall++;
                e_iss_v = acc;
                e_iss   = '0;
                if (acc) begin
                    e_iss = '{op: in_op, format: in_format, imm: in_imm,
                              rt_addr: in_rt_addr,
                              reg_write: in_reg_write};
                    if (in_reg_write) begin
                        ready_at[in_rt_addr] = cyc + int'(in_lat);
                        if (in_lat > 1) wb_res[cyc + int'(in_lat)] = 1;
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
